fib_stream_checker: RTL and testbench
=====================================

Name: fib_stream_checker

Overview:
- Consumer-side monitor for the Fibonacci number stream (F0=1, F1=1, Fn=Fn-1+Fn-2, modulo 2^DATA_WIDTH).
- Accepts one term per valid/ready beat and compares it against an internally tracked expected value.
- Reports per-beat match/mismatch pulses, the current run length, and a sticky error.
- Sits at the receiving end of a generator's output for self-check and BIST.

Parameters:
DATA_WIDTH, 32, width of each sequence term; all arithmetic wraps modulo 2^DATA_WIDTH
CNT_WIDTH, 16, width of run_len counter; saturates at 2^CNT_WIDTH-1

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
in_valid  input  1  in_data holds a term this cycle
in_ready  output  1  checker can accept a term; beat accepted when in_valid && in_ready
in_data  input  DATA_WIDTH  incoming sequence term
err_clr  input  1  single-cycle pulse; clears error and restarts tracking
expected  output  DATA_WIDTH  value the next accepted beat must equal (combinational from state regs)
match  output  1  registered pulse, high the cycle after an accepted beat that equalled expected
mismatch  output  1  registered pulse, high the cycle after an accepted beat that differed from expected
err  output  1  sticky error flag
run_len  output  CNT_WIDTH  consecutive matched terms in current sequence, saturating

Behaviour:
- Reset (resetn=0 at clk edge), effective the following cycle and overriding all other inputs:
  - state=IDLE; prev=0, cur=0, run_len=0.
  - match=0, mismatch=0, err=0.
  - expected=1, in_ready=1.
- State machine, evaluated only on an accepted beat unless noted:
  - IDLE: expected=1. in_data==1 -> SEED, run_len=1, match. Otherwise -> ERROR, mismatch.
  - SEED: expected=1. in_data==1 -> TRACK, prev=1, cur=1, run_len=2, match. Otherwise -> ERROR, mismatch.
  - TRACK: expected=(cur+prev) mod 2^DATA_WIDTH. Equal -> prev<=cur, cur<=in_data, run_len+1 (saturating), match. Otherwise -> ERROR, mismatch.
  - ERROR: in_ready=0, err=1, run_len holds the value at the mismatch. err_clr -> IDLE, err=0, run_len=0, prev=cur=0.
- Handshake and gaps:
  - in_ready = (state != ERROR), combinational.
  - No beat is accepted while in_ready=0.
  - in_valid low: no state change, match=mismatch=0.
- Latency:
  - match, mismatch and run_len update one cycle after the accepting edge.
  - expected reflects the new state in that same cycle.
- Wrap-around: addition is truncated to DATA_WIDTH. No overflow flag. A wrapped term that equals the truncated sum is a match.
- run_len at 2^CNT_WIDTH-1 stays there on further matches.
- Simultaneous events:
  - err_clr and in_valid in ERROR: beat not accepted (in_ready=0); clear takes effect.
  - err_clr outside ERROR: ignored (base build).
  - resetn low dominates err_clr and in_valid.
- match and mismatch are never high together.

Optional Feature:
Macro FIB_CHK_RESYNC_EN.
- Defined:
  - ERROR state is not entered, and in_ready is constantly 1.
  - On mismatch: err set sticky and mismatch pulses.
  - If the mismatching in_data==1 -> SEED with run_len=1 (treated as a new F0). Otherwise -> IDLE with run_len=0.
  - err_clr clears err in any state, without changing tracking state.
  - A mismatch in the same cycle as err_clr leaves err=1 (set wins).
- Undefined: base behaviour above (halt in ERROR until err_clr).

Test Plan:
1. Reset, then beats 1,1,2,3,5,8 back-to-back -> six match pulses, zero mismatch; run_len=6, expected=13, err=0, in_ready=1.
2. Beats 1,1,2,4 -> mismatch pulse after the 4th beat; err=1, in_ready=0, run_len=3. Hold in_valid=1 for 3 cycles -> nothing accepted. Pulse err_clr -> next cycle err=0, run_len=0, expected=1, in_ready=1.
3. Beats 1, idle 3 cycles, 1, idle 1 cycle, 2 -> three match pulses only on accept cycles; run_len=3, expected=3.
4. DATA_WIDTH=8: feed correct sequence through 144,233 -> expected=121 (377 mod 256). Feed 121 -> match, next expected=98.
5. resetn low for one cycle after 1,1,2,3 -> following cycle run_len=0, expected=1, match=mismatch=err=0. Then beat 1 -> match, run_len=1.
6. With FIB_CHK_RESYNC_EN:
   - 1,1,2,4,1,1 -> mismatch on 4, err=1 sticky, in_ready always 1, final run_len=2.
   - Separately 1,1,2,1 -> mismatch, then state SEED, run_len=1, expected=1.

Source files
------------

// File: rtl/fib_stream_checker.sv
// Consumer-side checker for the Fibonacci stream (F0=F1=1, modulo 2^DATA_WIDTH).
// Define FIB_CHK_RESYNC_EN to resynchronise on mismatch instead of halting in ERROR.
module fib_stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] expected,
  output logic                  match,
  output logic                  mismatch,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  run_len,
  output logic [1:0]            dbg_state
);

  // Handshake: a term is consumed on a rising edge where in_valid && in_ready;
  // in_data must be stable while in_valid is high, in_ready depends only on state.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_TRACK = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] prev, cur, prev_nxt, cur_nxt;
  logic [CNT_WIDTH-1:0]  run_len_nxt, run_len_inc;
  logic                  match_nxt, mismatch_nxt, err_nxt;
  logic                  accept, hit;

  assign dbg_state   = state;
  assign expected    = (state == S_TRACK) ? DATA_WIDTH'(cur + prev) : DATA_WIDTH'(1);
  assign run_len_inc = (run_len == '1) ? run_len : run_len + CNT_WIDTH'(1);

`ifdef FIB_CHK_RESYNC_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = (state != S_ERROR);
`endif

  assign accept = in_valid && in_ready;
  assign hit    = (in_data == expected);

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    cur_nxt      = cur;
    run_len_nxt  = run_len;
    match_nxt    = 1'b0;
    mismatch_nxt = 1'b0;
    err_nxt      = err;
`ifdef FIB_CHK_RESYNC_EN
    // Clear is applied first so a simultaneous mismatch re-sets the flag.
    if (err_clr) err_nxt = 1'b0;
`endif
    if (accept) begin
      if (hit) begin
        match_nxt   = 1'b1;
        run_len_nxt = run_len_inc;
        case (state)
          S_IDLE: state_nxt = S_SEED;
          S_SEED: begin
            state_nxt = S_TRACK;
            prev_nxt  = DATA_WIDTH'(1);
            cur_nxt   = DATA_WIDTH'(1);
          end
          S_TRACK: begin
            prev_nxt = cur;
            cur_nxt  = in_data;
          end
          default: ;
        endcase
      end else begin
        mismatch_nxt = 1'b1;
        err_nxt      = 1'b1;
`ifdef FIB_CHK_RESYNC_EN
        // A mismatching 1 is taken as the F0 of a fresh sequence.
        prev_nxt = '0;
        cur_nxt  = '0;
        if (in_data == DATA_WIDTH'(1)) begin
          state_nxt   = S_SEED;
          run_len_nxt = CNT_WIDTH'(1);
        end else begin
          state_nxt   = S_IDLE;
          run_len_nxt = '0;
        end
`else
        state_nxt = S_ERROR;
`endif
      end
    end
`ifdef FIB_CHK_RESYNC_EN
`else
    if (state == S_ERROR && err_clr) begin
      state_nxt   = S_IDLE;
      err_nxt     = 1'b0;
      run_len_nxt = '0;
      prev_nxt    = '0;
      cur_nxt     = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      prev     <= '0;
      cur      <= '0;
      run_len  <= '0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      cur      <= cur_nxt;
      run_len  <= run_len_nxt;
      match    <= match_nxt;
      mismatch <= mismatch_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker (8-bit terms, 4-bit run counter); honours FIB_CHK_RESYNC_EN.
module tb_fib_stream_checker;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] expected;
  logic          match, mismatch, err;
  logic [CW-1:0] run_len;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model: position within the Fibonacci sequence plus flags.
  int   m_pos = 0;
  logic m_err = 1'b0, m_halt = 1'b0, m_match = 1'b0, m_mismatch = 1'b0;

  fib_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .err_clr(err_clr), .expected(expected), .match(match),
    .mismatch(mismatch), .err(err), .run_len(run_len), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fib_mod(input int n);
    logic [DW-1:0] a, b, t;
    a = 1; b = 1;
    for (int i = 2; i <= n; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] m_run_len();
    return (m_pos > 15) ? CW'(15) : CW'(m_pos);
  endfunction

  function automatic logic m_ready();
`ifdef FIB_CHK_RESYNC_EN
    return 1'b1;
`else
    return !m_halt;
`endif
  endfunction

  task automatic model_step(input logic rn, input logic v, input logic [DW-1:0] d, input logic c);
    logic acc;
    if (!rn) begin
      m_pos = 0; m_err = 0; m_halt = 0; m_match = 0; m_mismatch = 0;
    end else begin
      acc = v && m_ready();
      m_match = 0; m_mismatch = 0;
`ifdef FIB_CHK_RESYNC_EN
      if (c) m_err = 0;
`endif
      if (acc) begin
        if (d == fib_mod(m_pos)) begin
          m_pos++; m_match = 1;
        end else begin
          m_mismatch = 1; m_err = 1;
`ifdef FIB_CHK_RESYNC_EN
          m_pos = (d == 1) ? 1 : 0;
`else
          m_halt = 1;
`endif
        end
      end else if (m_halt && c) begin
        m_halt = 0; m_err = 0; m_pos = 0;
      end
    end
  endtask

  task automatic cycle(input logic rn, input logic v, input logic [DW-1:0] d, input logic c);
    resetn = rn; in_valid = v; in_data = d; err_clr = c;
    @(posedge clk);
    model_step(rn, v, d, c);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1, 8'd1, 1);
    cycle(0, 0, 8'd0, 0);
    checks++; if (run_len !== 0) begin failures++; $display("FAIL reset_run_len got=%0d exp=0", run_len); end
    checks++; if (expected !== 1) begin failures++; $display("FAIL reset_expected got=%0d exp=1", expected); end
    checks++; if (in_ready !== 1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if ({match, mismatch, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {match, mismatch, err}); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seq[6] = '{1, 1, 2, 3, 5, 8};
    cycle(0, 0, 0, 0);
    foreach (seq[i]) begin
      cycle(1, 1, seq[i], 0);
      checks++; if (match !== 1 || mismatch !== 0) begin failures++; $display("FAIL b2b_pulse beat=%0d got=%b%b exp=10", i, match, mismatch); end
    end
    cycle(1, 0, 0, 0);
    checks++; if (run_len !== 6) begin failures++; $display("FAIL b2b_run_len got=%0d exp=6", run_len); end
    checks++; if (expected !== 13) begin failures++; $display("FAIL b2b_expected got=%0d exp=13", expected); end
    checks++; if (err !== 0 || in_ready !== 1) begin failures++; $display("FAIL b2b_err_ready got=%b%b exp=01", err, in_ready); end
  endtask

`ifdef FIB_CHK_RESYNC_EN
  task automatic test_resync();
    logic [DW-1:0] seq[6] = '{1, 1, 2, 4, 1, 1};
    cycle(0, 0, 0, 0);
    foreach (seq[i]) begin
      checks++; if (in_ready !== 1) begin failures++; $display("FAIL rs_ready beat=%0d got=%b exp=1", i, in_ready); end
      cycle(1, 1, seq[i], 0);
      checks++; if (mismatch !== (i == 3)) begin failures++; $display("FAIL rs_mismatch beat=%0d got=%b exp=%b", i, mismatch, i == 3); end
      checks++; if (err !== (i >= 3)) begin failures++; $display("FAIL rs_err beat=%0d got=%b exp=%b", i, err, i >= 3); end
    end
    checks++; if (run_len !== 2) begin failures++; $display("FAIL rs_run_len got=%0d exp=2", run_len); end
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 0); cycle(1, 1, 1, 0); cycle(1, 1, 2, 0); cycle(1, 1, 1, 0);
    checks++; if (mismatch !== 1) begin failures++; $display("FAIL rs2_mismatch got=%b exp=1", mismatch); end
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL rs2_state got=%0d exp=1", dbg_state); end
    checks++; if (run_len !== 1 || expected !== 1) begin failures++; $display("FAIL rs2_len_exp got=%0d/%0d exp=1/1", run_len, expected); end
    cycle(1, 0, 0, 1);
    checks++; if (err !== 0 || run_len !== 1) begin failures++; $display("FAIL rs2_clr got=%b/%0d exp=0/1", err, run_len); end
  endtask
`else
  task automatic test_error_halt();
    logic [DW-1:0] seq[4] = '{1, 1, 2, 4};
    cycle(0, 0, 0, 0);
    foreach (seq[i]) begin
      cycle(1, 1, seq[i], 0);
      checks++; if (mismatch !== (i == 3) || match !== (i != 3)) begin failures++; $display("FAIL halt_pulse beat=%0d got=%b%b", i, match, mismatch); end
    end
    checks++; if (err !== 1 || in_ready !== 0 || run_len !== 3) begin failures++; $display("FAIL halt_state got=err%b rdy%b len%0d exp=err1 rdy0 len3", err, in_ready, run_len); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 8'd3, 0);
      checks++; if (match !== 0 || mismatch !== 0 || run_len !== 3) begin failures++; $display("FAIL halt_hold got=%b%b len%0d exp=00 len3", match, mismatch, run_len); end
    end
    cycle(1, 1, 8'd1, 1);
    checks++; if (err !== 0 || run_len !== 0 || expected !== 1 || in_ready !== 1 || match !== 0) begin
      failures++; $display("FAIL halt_clr got=err%b len%0d exp%0d rdy%b m%b exp=err0 len0 exp1 rdy1 m0", err, run_len, expected, in_ready, match);
    end
  endtask
`endif

  task automatic test_gaps();
    logic       v[7] = '{1, 0, 0, 0, 1, 0, 1};
    logic [7:0] d[7] = '{1, 0, 0, 0, 1, 0, 2};
    cycle(0, 0, 0, 0);
    foreach (v[i]) begin
      cycle(1, v[i], v[i] ? d[i] : 8'($urandom_range(0, 255)), 0);
      checks++; if (match !== v[i] || mismatch !== 0) begin failures++; $display("FAIL gap_pulse cyc=%0d got=%b%b exp=%b0", i, match, mismatch, v[i]); end
    end
    checks++; if (run_len !== 3 || expected !== 3) begin failures++; $display("FAIL gap_end got=%0d/%0d exp=3/3", run_len, expected); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] seq[13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    cycle(0, 0, 0, 0);
    foreach (seq[i]) cycle(1, 1, seq[i], 0);
    checks++; if (expected !== 121) begin failures++; $display("FAIL wrap_expected got=%0d exp=121", expected); end
    cycle(1, 1, 8'd121, 0);
    checks++; if (match !== 1 || expected !== 98) begin failures++; $display("FAIL wrap_next got=m%b exp%0d exp=m1 98", match, expected); end
    cycle(1, 1, 8'd98, 0);
    checks++; if (run_len !== 15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", run_len); end
    cycle(1, 1, 8'd219, 0);
    cycle(1, 1, 8'd61, 0);
    checks++; if (run_len !== 15 || match !== 1) begin failures++; $display("FAIL sat_hold got=%0d m%b exp=15 m1", run_len, match); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] seq[4] = '{1, 1, 2, 3};
    cycle(0, 0, 0, 0);
    foreach (seq[i]) cycle(1, 1, seq[i], 0);
    cycle(0, 1, 8'd5, 1);
    checks++; if (run_len !== 0 || expected !== 1 || {match, mismatch, err} !== 3'b000) begin
      failures++; $display("FAIL rstmid got=len%0d exp%0d f%b exp=len0 exp1 f000", run_len, expected, {match, mismatch, err});
    end
    cycle(1, 1, 8'd1, 0);
    checks++; if (match !== 1 || run_len !== 1) begin failures++; $display("FAIL rstmid_beat got=m%b len%0d exp=m1 len1", match, run_len); end
  endtask

  task automatic test_random();
    logic v, c, rn;
    logic [DW-1:0] d;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 9) < 8) ? fib_mod(m_pos) : 8'($urandom_range(0, 255));
      c  = ($urandom_range(0, 11) == 0);
      cycle(rn, v, d, c);
      checks++; if (match !== m_match || mismatch !== m_mismatch) begin failures++; $display("FAIL rnd_pulse cyc=%0d got=%b%b exp=%b%b", i, match, mismatch, m_match, m_mismatch); end
      checks++; if (err !== m_err || in_ready !== m_ready()) begin failures++; $display("FAIL rnd_err_rdy cyc=%0d got=%b%b exp=%b%b", i, err, in_ready, m_err, m_ready()); end
      checks++; if (run_len !== m_run_len()) begin failures++; $display("FAIL rnd_run_len cyc=%0d got=%0d exp=%0d", i, run_len, m_run_len()); end
      if (!m_halt) begin
        checks++; if (expected !== fib_mod(m_pos)) begin failures++; $display("FAIL rnd_expected cyc=%0d got=%0d exp=%0d", i, expected, fib_mod(m_pos)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
`ifdef FIB_CHK_RESYNC_EN
    test_resync();
`else
    test_error_halt();
`endif
    test_gaps();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
